// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - 8N1 UART receiver with mid-bit sampling, framing-error strobe and break hold-off.
module serial_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rxData,
  output logic       rxReady,
  output logic       rxError,
  output logic       rxActive
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  // Declaration initialisers make power-up state identical to the reset state.
  logic          sync1   = 1'b1;
  logic          rxs     = 1'b1;
  state_t        state   = IDLE;
  logic [CW-1:0] cnt     = '0;
  logic [2:0]    bit_idx = '0;
  logic [7:0]    shreg   = '0;
  logic [7:0]    data_q  = '0;
  logic          ready_q = 1'b0;
  logic          error_q = 1'b0;

  state_t        state_n;
  logic [CW-1:0] cnt_n;
  logic [2:0]    bit_n;
  logic [7:0]    shreg_n;
  logic [7:0]    data_n;
  logic          ready_n;
  logic          error_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b1;
      rxs     <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      sync1   <= rx;
      rxs     <= sync1;
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shreg   <= shreg_n;
      data_q  <= data_n;
      ready_q <= ready_n;
      error_q <= error_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = '0;
    bit_n   = bit_idx;
    shreg_n = shreg;
    data_n  = data_q;
    ready_n = 1'b0;
    error_n = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) state_n = START;
      end
      START: begin
        // Re-check the line at mid start bit to reject short glitches.
        if (cnt == HALF_M1) begin
          state_n = rxs ? IDLE : DATA;
          bit_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == BIT_M1) begin
          shreg_n = {rxs, shreg[7:1]};
          bit_n   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt == BIT_M1) begin
          if (rxs) begin
            data_n  = shreg;
            ready_n = 1'b1;
            state_n = IDLE;
          end else begin
            error_n = 1'b1;
            state_n = BREAK;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      BREAK: begin
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign rxData   = data_q;
  assign rxReady  = ready_q;
  assign rxError  = error_q;
  assign rxActive = (state != IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// tb/tb_serial_rx.sv - directed and randomized frame checks of serial_rx against an event-list model.
module tb_serial_rx;

  localparam int C    = 16;
  localparam int HALF = C / 2;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] rxData;
  logic       rxReady;
  logic       rxError;
  logic       rxActive;

  serial_rx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .rxData(rxData), .rxReady(rxReady), .rxError(rxError), .rxActive(rxActive)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         err;
    int         edge_n;
    logic [7:0] data;
  } ev_t;

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  ev_t        mon_e;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         viol = 0;
  int         act_run = 0;
  int         act_max = 0;
  logic [7:0] model_data = 8'h00;
  logic       prev_ready = 1'b0;
  logic       prev_error = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Edge numbers recorded here match the numbering used by send().
  always begin
    @(posedge clk);
    #1;
    if (rxReady === 1'b1 || rxError === 1'b1) begin
      mon_e.err    = (rxError === 1'b1);
      mon_e.edge_n = cyc;
      mon_e.data   = rxData;
      obs_q.push_back(mon_e);
    end
    if (rxReady === 1'b1 && rxError === 1'b1) viol++;
    if ((rxReady === 1'b1 && prev_ready) || (rxError === 1'b1 && prev_error)) viol++;
    if (reset !== 1'b1 && rxData !== prev_data && rxReady !== 1'b1) viol++;
    prev_ready = (rxReady === 1'b1);
    prev_error = (rxError === 1'b1);
    prev_data  = rxData;
    if (rxActive === 1'b1) act_run++; else act_run = 0;
    if (act_run > act_max) act_max = act_run;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  // Model: a frame whose start bit is first sampled at edge f reports at
  // f + 2 (synchronizer) + HALF + 9 bit times.
  task automatic send(input logic [7:0] d, input logic stop_bit);
    ev_t e;
    int  f;
    f = cyc + 1;
    hold(1'b0, C);
    for (int i = 0; i < 8; i++) hold(d[i], C);
    hold(stop_bit, C);
    if (stop_bit) model_data = d;
    e.err    = !stop_bit;
    e.edge_n = f + 2 + HALF + 9 * C;
    e.data   = model_data;
    exp_q.push_back(e);
  endtask

  task automatic compare_events(input string tag);
    ev_t o;
    ev_t x;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      o = obs_q.pop_front();
      x = exp_q.pop_front();
      check({tag, "_edge"}, o.edge_n, x.edge_n);
      check({tag, "_kind"}, {31'd0, o.err}, {31'd0, x.err});
      check({tag, "_data"}, {24'd0, o.data}, {24'd0, x.data});
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    logic       sb;
    int         gap;
    int         b2b;

    #1;
    check("pwrup_data", {24'd0, rxData}, 32'h00);
    check("pwrup_ready", {31'd0, rxReady}, 32'd0);
    check("pwrup_error", {31'd0, rxError}, 32'd0);
    check("pwrup_active", {31'd0, rxActive}, 32'd0);

    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_data", {24'd0, rxData}, 32'h00);
    check("rst_active", {31'd0, rxActive}, 32'd0);
    hold(1'b1, 10);
    check("rst_no_events", obs_q.size(), 0);
    obs_q.delete();

    send(8'h55, 1'b1);
    hold(1'b1, 20);
    compare_events("f55");

    send(8'hA5, 1'b1);
    send(8'h3C, 1'b1);
    hold(1'b1, 20);
    b2b = (obs_q.size() >= 2) ? (obs_q[1].edge_n - obs_q[0].edge_n) : -1;
    check("b2b_gap", b2b, 10 * C);
    compare_events("b2b");

    act_max = 0;
    hold(1'b0, 4);
    hold(1'b1, 30);
    check("glitch_active_le10", {31'd0, (act_max <= 10)}, 32'd1);
    check("glitch_active_seen", {31'd0, (act_max > 0)}, 32'd1);
    compare_events("glitch");

    send(8'hFF, 1'b0);
    hold(1'b0, 40);
    check("brk_data_held", {24'd0, rxData}, 32'h3C);
    check("brk_active", {31'd0, rxActive}, 32'd1);
    compare_events("brk");
    hold(1'b1, 20);
    check("brk_exit_quiet", obs_q.size(), 0);
    send(8'h12, 1'b1);
    hold(1'b1, 20);
    compare_events("after_brk");
    check("after_brk_data", {24'd0, rxData}, 32'h12);

    hold(1'b0, 4 * C);
    reset = 1'b1;
    model_data = 8'h00;
    @(negedge clk);
    check("midrst_data", {24'd0, rxData}, 32'h00);
    check("midrst_ready", {31'd0, rxReady}, 32'd0);
    check("midrst_error", {31'd0, rxError}, 32'd0);
    check("midrst_active", {31'd0, rxActive}, 32'd0);
    reset = 1'b0;
    hold(1'b1, 8 * C);
    compare_events("midrst");
    send(8'h81, 1'b1);
    hold(1'b1, 20);
    compare_events("after_rst");

    for (int n = 0; n < 24; n++) begin
      d   = 8'($urandom);
      sb  = ($urandom_range(0, 3) != 0);
      send(d, sb);
      gap = $urandom_range(sb ? 0 : 1, 25);
      if (gap > 0) hold(1'b1, gap);
    end
    hold(1'b1, 20);
    compare_events("rand");
    check("final_data", {24'd0, rxData}, {24'd0, model_data});
    check("strobe_rules", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
